// File: rtl/frame_store_writer.sv
// Frame store writer: accepts a raster of pixel beats and turns each accepted
// beat into one registered memory write. Rows may be stored bottom-up and the
// channel order inside each pixel may be reversed. Every row starts on a
// 4-byte boundary, and the pad bytes at the end of a row are never written.
module frame_store_writer #(
    parameter int WIDTH        = 956,
    parameter int HEIGHT       = 635,
    parameter int PIX_PER_BEAT = 2,
    parameter int CH           = 3,
    parameter int DW           = 8,
    parameter int BOTTOM_UP    = 1,
    parameter int REVERSE_CH   = 1,
    parameter int ADDR_W       = 22
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [PIX_PER_BEAT*CH*DW-1:0]    in_data,
    output logic                             in_ready,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [PIX_PER_BEAT*CH*DW-1:0]    mem_wdata,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             drop_err
);

    localparam int BW         = PIX_PER_BEAT * CH * DW;
    localparam int BEAT_BYTES = BW / 8;
    localparam int ROW_BYTES  = WIDTH * CH * DW / 8;
    localparam int ROW_STRIDE = ((ROW_BYTES + 3) / 4) * 4;
    localparam int COLS       = WIDTH / PIX_PER_BEAT;
    localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                drop_err_q, drop_err_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                accept, arm, col_last, row_last;
    logic [ADDR_W-1:0]   row_sel;

    // Reorders the channels of every pixel into memory byte order: pixel 0 at
    // the lowest bits, and inside a pixel either channel CH-1 or channel 0 lowest.
    function automatic logic [BW-1:0] pack_beat(input logic [BW-1:0] din);
        logic [BW-1:0] dout;
        int            ch;
        dout = '0;
        for (int p = 0; p < PIX_PER_BEAT; p++) begin
            for (int s = 0; s < CH; s++) begin
                ch = (REVERSE_CH != 0) ? (CH - 1 - s) : s;
                dout[p*CH*DW + s*DW +: DW] = din[p*CH*DW + (CH-1-ch)*DW +: DW];
            end
        end
        return dout;
    endfunction

    assign accept   = in_valid && (state_q == S_ACTIVE);
    assign arm      = (state_q == S_IDLE) && start;
    assign col_last = (col_q == CW'(COLS - 1));
    assign row_last = (row_q == RW'(HEIGHT - 1));

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: the frame ends when the final beat of the last row is accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACTIVE;
            S_ACTIVE: if (accept && col_last && row_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; DONE lines up with the write of the final beat
    always_comb begin
        in_ready   = (state_q == S_ACTIVE);
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
    end

    // Column/row counters and sticky error next-state
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        drop_err_d = drop_err_q;
        if (arm) begin
            col_d      = '0;
            row_d      = '0;
            drop_err_d = 1'b0;
        end else if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // A beat offered outside ACTIVE is discarded and flagged
        if (in_valid && (state_q != S_ACTIVE)) drop_err_d = 1'b1;
    end

    // Write request next-state: address and data only move on an accepted beat
    always_comb begin
        row_sel     = (BOTTOM_UP != 0) ? (ADDR_W'(HEIGHT - 1) - ADDR_W'(row_q))
                                       : ADDR_W'(row_q);
        mem_we_d    = accept;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (accept) begin
            mem_addr_d  = row_sel * ADDR_W'(ROW_STRIDE)
                        + ADDR_W'(col_q) * ADDR_W'(BEAT_BYTES);
            mem_wdata_d = pack_beat(in_data);
        end
    end

    // Counter, error flag and write-port registers
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            col_q       <= '0;
            row_q       <= '0;
            drop_err_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            drop_err_q  <= drop_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_frame_store_writer.sv
// Scoreboard bench for frame_store_writer. Three instances cover bottom-up with
// reversed channels (A), top-down with straight channels (B, driven in lockstep
// with A), and a padded-row geometry (C).
module tb_frame_store_writer;

    typedef struct {
        logic [21:0] addr;
        logic [47:0] data;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic HRESETn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // A/B shared stimulus
    logic        start_ab = 1'b0, in_valid_ab = 1'b0;
    logic [47:0] in_data_ab = '0;
    logic        in_ready_a, mem_we_a, busy_a, frame_done_a, drop_err_a;
    logic [21:0] mem_addr_a;
    logic [47:0] mem_wdata_a;
    logic        in_ready_b, mem_we_b, busy_b, frame_done_b, drop_err_b;
    logic [21:0] mem_addr_b;
    logic [47:0] mem_wdata_b;
    // C stimulus
    logic        start_c = 1'b0, in_valid_c = 1'b0;
    logic [47:0] in_data_c = '0;
    logic        in_ready_c, mem_we_c, busy_c, frame_done_c, drop_err_c;
    logic [21:0] mem_addr_c;
    logic [47:0] mem_wdata_c;

    logic [7:0] memc [0:23];

    frame_store_writer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_BEAT(2), .CH(3), .DW(8),
                         .BOTTOM_UP(1), .REVERSE_CH(1), .ADDR_W(22)) dut_a (
        .HCLK(clk), .HRESETn(HRESETn), .start(start_ab), .in_valid(in_valid_ab),
        .in_data(in_data_ab), .in_ready(in_ready_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .busy(busy_a),
        .frame_done(frame_done_a), .drop_err(drop_err_a));

    frame_store_writer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_BEAT(2), .CH(3), .DW(8),
                         .BOTTOM_UP(0), .REVERSE_CH(0), .ADDR_W(22)) dut_b (
        .HCLK(clk), .HRESETn(HRESETn), .start(start_ab), .in_valid(in_valid_ab),
        .in_data(in_data_ab), .in_ready(in_ready_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .busy(busy_b),
        .frame_done(frame_done_b), .drop_err(drop_err_b));

    frame_store_writer #(.WIDTH(2), .HEIGHT(3), .PIX_PER_BEAT(2), .CH(3), .DW(8),
                         .BOTTOM_UP(1), .REVERSE_CH(1), .ADDR_W(22)) dut_c (
        .HCLK(clk), .HRESETn(HRESETn), .start(start_c), .in_valid(in_valid_c),
        .in_data(in_data_c), .in_ready(in_ready_c), .mem_we(mem_we_c),
        .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c), .busy(busy_c),
        .frame_done(frame_done_c), .drop_err(drop_err_c));

    // Hand-computed beats: D* is the input, EB* the straight-channel memory image
    localparam logic [47:0] D0 = 48'h445566_112233, EB0 = 48'h665544_332211;
    localparam logic [47:0] D1 = 48'hA1A2A3_B1B2B3, EB1 = 48'hA3A2A1_B3B2B1;
    localparam logic [47:0] D2 = 48'h0F0E0D_0C0B0A, EB2 = 48'h0D0E0F_0A0B0C;
    localparam logic [47:0] D3 = 48'hFF0080_7F0100, EB3 = 48'h8000FF_00017F;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, inout exp_t q[$], input logic [21:0] addr,
                           input logic [47:0] data, input logic done);
        exp_t e;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_write actual addr=%0d expected none", tag, addr);
        end else begin
            e = q.pop_front();
            chk({tag, "_addr"}, 64'(addr), 64'(e.addr));
            chk({tag, "_wdata"}, 64'(data), 64'(e.data));
            chk({tag, "_frame_done"}, 64'(done), 64'(e.done));
        end
    endtask

    // Monitors: every write is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (mem_we_a) pop_cmp("a", qa, mem_addr_a, mem_wdata_a, frame_done_a);
        else if (frame_done_a) begin errors++; $display("FAIL a_done_without_write actual=1 expected=0"); end
        if (mem_we_b) pop_cmp("b", qb, mem_addr_b, mem_wdata_b, frame_done_b);
        else if (frame_done_b) begin errors++; $display("FAIL b_done_without_write actual=1 expected=0"); end
        if (mem_we_c) begin
            for (int k = 0; k < 6; k++)
                if (int'(mem_addr_c) + k < 24) memc[int'(mem_addr_c) + k] = mem_wdata_c[8*k +: 8];
            pop_cmp("c", qc, mem_addr_c, mem_wdata_c, frame_done_c);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_frame_ab();
        start_ab = 1'b1; tick(); start_ab = 1'b0;
    endtask

    task automatic send_ab(input logic [47:0] d, input logic [47:0] eb,
                           input logic [21:0] aa, input logic [21:0] ab, input logic last);
        int n = 0;
        exp_t ea, ebx;
        in_valid_ab = 1'b1; in_data_ab = d;
        while (!in_ready_a && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            errors++;
            $display("FAIL ab_ready_timeout actual=0 expected=1");
        end else begin
            ea.addr = aa; ea.data = d;  ea.done = last; qa.push_back(ea);
            ebx.addr = ab; ebx.data = eb; ebx.done = last; qb.push_back(ebx);
        end
        tick();
        in_valid_ab = 1'b0;
    endtask

    task automatic send_c(input logic [47:0] d, input logic [21:0] ac, input logic last);
        int n = 0;
        exp_t e;
        in_valid_c = 1'b1; in_data_c = d;
        while (!in_ready_c && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            errors++;
            $display("FAIL c_ready_timeout actual=0 expected=1");
        end else begin
            e.addr = ac; e.data = d; e.done = last; qc.push_back(e);
        end
        tick();
        in_valid_c = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready_a), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we_a), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr_a), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata_a), 64'd0);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done_a), 64'd0);
        chk({tag, "_drop_err"}, 64'(drop_err_a), 64'd0);
    endtask

    // Watchdog keeps the run bounded
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        for (int i = 0; i < 24; i++) memc[i] = 8'hEE;
        HRESETn = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        HRESETn = 1'b1;
        tick();

        // Back-to-back frame
        start_frame_ab();
        chk("busy_after_start", 64'(busy_a), 64'd1);
        send_ab(D0, EB0, 22'd12, 22'd0,  1'b0);
        send_ab(D1, EB1, 22'd18, 22'd6,  1'b0);
        send_ab(D2, EB2, 22'd0,  22'd12, 1'b0);
        send_ab(D3, EB3, 22'd6,  22'd18, 1'b1);
        chk("ready_low_after_last", 64'(in_ready_a), 64'd0);
        chk("frame_done_with_last", 64'(frame_done_a), 64'd1);
        chk("busy_in_done", 64'(busy_a), 64'd1);
        tick();
        chk("busy_back_idle", 64'(busy_a), 64'd0);
        chk("frame_done_one_cycle", 64'(frame_done_b), 64'd0);

        // Stalled frame: in_valid alternates 1/0
        start_frame_ab();
        send_ab(D3, EB3, 22'd12, 22'd0,  1'b0); tick();
        send_ab(D2, EB2, 22'd18, 22'd6,  1'b0); tick();
        send_ab(D1, EB1, 22'd0,  22'd12, 1'b0); tick();
        send_ab(D0, EB0, 22'd6,  22'd18, 1'b1); tick();
        tick();

        // Beat offered while idle is dropped and flagged
        in_valid_ab = 1'b1; in_data_ab = D1;
        tick();
        in_valid_ab = 1'b0;
        chk("drop_err_set_a", 64'(drop_err_a), 64'd1);
        chk("drop_err_set_b", 64'(drop_err_b), 64'd1);
        chk("no_write_on_drop", 64'(mem_we_a), 64'd0);
        tick();
        chk("drop_err_sticky", 64'(drop_err_a), 64'd1);
        start_frame_ab();
        chk("drop_err_cleared", 64'(drop_err_a), 64'd0);

        // Reset in the middle of a frame
        send_ab(D0, EB0, 22'd12, 22'd0, 1'b0);
        send_ab(D1, EB1, 22'd18, 22'd6, 1'b0);
        HRESETn = 1'b0;
        tick();
        chk_all_zero("midreset");
        HRESETn = 1'b1;
        tick();
        chk("idle_after_reset_ready", 64'(in_ready_a), 64'd0);
        start_frame_ab();
        send_ab(D2, EB2, 22'd12, 22'd0,  1'b0);
        send_ab(D3, EB3, 22'd18, 22'd6,  1'b0);
        send_ab(D0, EB0, 22'd0,  22'd12, 1'b0);
        send_ab(D1, EB1, 22'd6,  22'd18, 1'b1);
        tick();

        // Padded rows: stride 8, bottom-up
        start_c = 1'b1; tick(); start_c = 1'b0;
        send_c(D0, 22'd16, 1'b0);
        send_c(D1, 22'd8,  1'b0);
        send_c(D2, 22'd0,  1'b1);
        repeat (3) tick();
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("pad_row%0d_b6", r), 64'(memc[r*8 + 6]), 64'hEE);
            chk($sformatf("pad_row%0d_b7", r), 64'(memc[r*8 + 7]), 64'hEE);
        end
        chk("c_row0_byte0", 64'(memc[0]), 64'h0A);
        chk("c_row2_byte5", 64'(memc[21]), 64'h44);

        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        chk("qc_drained", 64'(qc.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_store_writer.md
FRAME_STORE_WRITER -- requirements
Module: frame_store_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 956: frame width in pixels; WIDTH % PIX_PER_BEAT == 0.
REQ-002 SHALL have parameter HEIGHT, default 635: frame height in rows.
REQ-003 SHALL have parameter PIX_PER_BEAT, default 2: pixels carried per input beat, range 1..4.
REQ-004 SHALL have parameter CH, default 3: channels per pixel, range 1..4.
REQ-005 SHALL have parameter DW, default 8: bits per channel.
REQ-006 SHALL have parameter BOTTOM_UP, default 1: 1 = last input row stored at lowest address; 0 = top-down.
REQ-007 SHALL have parameter REVERSE_CH, default 1: 1 = channel order reversed in memory (RGB in, BGR stored).
REQ-008 SHALL have parameter ADDR_W, default 22: byte-address width.
REQ-009 SHALL have port HCLK  in  1  clock; all logic on rising edge.
REQ-010 SHALL have port HRESETn  in  1  reset; synchronous, active-low.
REQ-011 SHALL have port start  in  1  arm one frame; sampled only in IDLE.
REQ-012 SHALL have port in_valid  in  1  beat present.
REQ-013 SHALL have port in_data  in  PIX_PER_BEAT*CH*DW  pixel p at bits [(p+1)*CH*DW-1 : p*CH*DW]; pixel 0 leftmost; channel 0 (R) is the MSB field of each pixel.
REQ-014 SHALL have port in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-015 SHALL have port mem_we  out  1  write strobe.
REQ-016 SHALL have port mem_addr  out  ADDR_W  byte address of the lowest byte of mem_wdata.
REQ-017 SHALL have port mem_wdata  out  PIX_PER_BEAT*CH*DW  byte k (bits [8k+7:8k]) goes to mem_addr+k.
REQ-018 SHALL have ports busy, frame_done and drop_err  out  1 each: frame in progress, one-cycle completion pulse, sticky protocol error.

Function
REQ-019 SHALL derive ROW_STRIDE = ceil(WIDTH*CH*DW/8 / 4)*4 bytes, so every row is padded to a 4-byte boundary; pad bytes are never written.
REQ-020 SHALL implement a 3-state FSM: IDLE -> ACTIVE on start; ACTIVE -> DONE on acceptance of the last beat; DONE -> IDLE unconditionally after one cycle.
REQ-021 SHALL drive in_ready = 1 only in ACTIVE, and busy = 1 in ACTIVE and DONE.
REQ-022 SHALL, on the IDLE->ACTIVE transition, clear the column counter (0..WIDTH/PIX_PER_BEAT-1), the row counter (0..HEIGHT-1) and drop_err.
REQ-023 SHALL advance the column counter per accepted beat; at its last value, wrap it to 0 and increment the row counter.
REQ-024 SHALL register the write one cycle after acceptance (latency 1): mem_we = 1, mem_addr = R*ROW_STRIDE + col*PIX_PER_BEAT*CH*DW/8, with R = HEIGHT-1-row if BOTTOM_UP else row.
REQ-025 SHALL place, in mem_wdata, pixel 0 at the lowest bytes; within a pixel, channel CH-1 is lowest when REVERSE_CH = 1 and channel 0 is lowest otherwise.
REQ-026 SHALL hold mem_we at 0 in every cycle without an acceptance in the previous cycle; mem_addr and mem_wdata hold their last values.
REQ-027 SHALL assert frame_done for exactly the DONE cycle, which coincides with the mem_we of the final beat.
REQ-028 SHALL set drop_err when in_valid = 1 in IDLE or DONE; the beat is discarded and no write occurs.
REQ-029 SHALL ignore start while in ACTIVE or DONE.
REQ-030 SHALL make in_valid low mid-row stall the counters without gaps or duplicated addresses.

Reset
REQ-031 SHALL, on HRESETn = 0 at a clock edge, force IDLE, counters 0, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, frame_done 0, drop_err 0.
REQ-032 SHALL abandon any frame that is mid-operation when reset occurs: no further writes, and a new start is required.

Verification (WIDTH=4, HEIGHT=2, PIX_PER_BEAT=2, CH=3, DW=8 unless stated)
REQ-033 SHALL verify bottom-up ordering: start, then 4 back-to-back beats -> mem_addr sequence 12, 18, 0, 6; frame_done high with the 4th mem_we; in_ready low after the 4th beat.
REQ-034 SHALL verify byte order: in_data pixel0 = R11 G22 B33, pixel1 = R44 G55 B66 with REVERSE_CH = 1 -> mem_wdata bytes 0..5 = 33 22 11 66 55 44; with REVERSE_CH = 0 -> 11 22 33 44 55 66.
REQ-035 SHALL verify padding: WIDTH=2, HEIGHT=3, BOTTOM_UP=1 -> ROW_STRIDE 8; addresses 16, 8, 0; bytes 6..7 of each row are untouched.
REQ-036 SHALL verify stalls and errors: in_valid toggled 1/0 every cycle -> 4 writes at the same addresses as REQ-033, no extras; in_valid while IDLE -> drop_err = 1, mem_we stays 0; next start clears drop_err.
REQ-037 SHALL verify reset mid-frame: HRESETn = 0 after 2 beats -> all outputs 0 next edge; a new start plus 4 beats -> addresses restart at 12.
REQ-038 SHALL verify top-down mode: BOTTOM_UP=0 -> addresses 0, 6, 12, 18.
